// File: rtl/gate_pkg.sv
// Shared types and constants for the two-beam gate passage decoder.
// The FSM encoding and the next-state rule live here so the top stays a flat register bank.
package gate_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int CNT_W                   = 8;

    // Filtered beam levels as {beam_a, beam_b}.
    localparam logic [1:0] LVL_NONE = 2'b00;
    localparam logic [1:0] LVL_A    = 2'b10;
    localparam logic [1:0] LVL_B    = 2'b01;
    localparam logic [1:0] LVL_AB   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IN1  = 3'd1,
        ST_IN2  = 3'd2,
        ST_IN3  = 3'd3,
        ST_OUT1 = 3'd4,
        ST_OUT2 = 3'd5,
        ST_OUT3 = 3'd6,
        ST_ERR  = 3'd7
    } state_t;

    // Entering walks A, AB, B, none; exiting is the same walk with A and B swapped.
    function automatic state_t fsm_next(input state_t s, input logic [1:0] lvl);
        state_t n;
        // NOTE: n starts as s so every path assigns it and "stay" needs no branch.
        n = s;
        unique case (s)
            ST_IDLE: begin
                case (lvl)
                    LVL_A:   n = ST_IN1;
                    LVL_B:   n = ST_OUT1;
                    LVL_AB:  n = ST_ERR;
                    default: n = ST_IDLE;
                endcase
            end
            ST_IN1: begin
                case (lvl)
                    LVL_AB:   n = ST_IN2;
                    LVL_NONE: n = ST_IDLE;
                    LVL_B:    n = ST_ERR;
                    default:  n = ST_IN1;
                endcase
            end
            ST_IN2: begin
                case (lvl)
                    LVL_B:    n = ST_IN3;
                    LVL_A:    n = ST_IN1;
                    LVL_NONE: n = ST_ERR;
                    default:  n = ST_IN2;
                endcase
            end
            ST_IN3: begin
                case (lvl)
                    LVL_NONE: n = ST_IDLE;
                    LVL_AB:   n = ST_IN2;
                    LVL_A:    n = ST_ERR;
                    default:  n = ST_IN3;
                endcase
            end
            ST_OUT1: begin
                case (lvl)
                    LVL_AB:   n = ST_OUT2;
                    LVL_NONE: n = ST_IDLE;
                    LVL_A:    n = ST_ERR;
                    default:  n = ST_OUT1;
                endcase
            end
            ST_OUT2: begin
                case (lvl)
                    LVL_A:    n = ST_OUT3;
                    LVL_B:    n = ST_OUT1;
                    LVL_NONE: n = ST_ERR;
                    default:  n = ST_OUT2;
                endcase
            end
            ST_OUT3: begin
                case (lvl)
                    LVL_NONE: n = ST_IDLE;
                    LVL_AB:   n = ST_OUT2;
                    LVL_B:    n = ST_ERR;
                    default:  n = ST_OUT3;
                endcase
            end
            ST_ERR: begin
                n = (lvl == LVL_NONE) ? ST_IDLE : ST_ERR;
            end
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// One beam channel: 2-flop synchronizer followed by a consecutive-cycle debounce counter.
// The filtered level flips only after DEBOUNCE_CYCLES consecutive synced samples disagree with it.
module debounce_filter
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/gate_pass_decoder.sv
// Two-beam gate passage decoder: debounced beams drive a direction FSM that strobes
// enter_pulse for an A-to-B passage and exit_pulse for a B-to-A passage.
module gate_pass_decoder
    import gate_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic beam_a_raw,
    input  logic beam_b_raw,
    output logic beam_a,
    output logic beam_b,
    output logic enter_pulse,
    output logic exit_pulse,
    output logic busy,
    output logic fault
);

    logic       w_beam_a;
    logic       w_beam_b;
    logic [1:0] w_level;
    state_t     w_next;

    state_t     r_state;
    logic       r_enter;
    logic       r_exit;
    logic       r_busy;
    logic       r_fault;

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter_a (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (beam_a_raw),
        .o_level (w_beam_a)
    );

    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter_b (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (beam_b_raw),
        .o_level (w_beam_b)
    );

    assign w_level = {w_beam_a, w_beam_b};
    assign w_next  = fsm_next(r_state, w_level);

    // Status outputs decode the next state so they line up with r_state, not one cycle behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_enter <= 1'b0;
            r_exit  <= 1'b0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_enter <= (r_state == ST_IN3)  && (w_level == LVL_NONE);
            r_exit  <= (r_state == ST_OUT3) && (w_level == LVL_NONE);
            r_busy  <= (w_next != ST_IDLE);
            r_fault <= (w_next == ST_ERR);
        end
    end

    assign beam_a      = w_beam_a;
    assign beam_b      = w_beam_b;
    assign enter_pulse = r_enter;
    assign exit_pulse  = r_exit;
    assign busy        = r_busy;
    assign fault       = r_fault;

endmodule

// File: tb/tb_gate_pass_decoder.sv
// Self-checking bench for gate_pass_decoder (DEBOUNCE_CYCLES=4): directed passages plus
// randomized beam activity against a sample-history / passage-walk reference model.
module tb_gate_pass_decoder;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    logic beam_a_raw;
    logic beam_b_raw;
    logic beam_a;
    logic beam_b;
    logic enter_pulse;
    logic exit_pulse;
    logic busy;
    logic fault;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Observed-event bookkeeping for directed scenarios.
    int enter_cnt      = 0;
    int exit_cnt       = 0;
    int last_enter_cyc = -1;
    int last_exit_cyc  = -1;
    bit busy_seen      = 0;
    bit fault_seen     = 0;
    bit a_seen         = 0;

    // Reference model state.
    bit ha[$];
    bit hb[$];
    bit m_fa, m_fb;
    int m_dir;        // 0 idle, 1 entering, 2 exiting
    int m_pos;        // position along the passage walk, 1..3
    bit m_err;
    bit m_enter, m_exit;

    gate_pass_decoder #(.DEBOUNCE_CYCLES(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .beam_a_raw  (beam_a_raw),
        .beam_b_raw  (beam_b_raw),
        .beam_a      (beam_a),
        .beam_b      (beam_b),
        .enter_pulse (enter_pulse),
        .exit_pulse  (exit_pulse),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // True when the last N synced samples (raw sampled two edges earlier) all differ from f.
    function automatic bit window_differs(input bit chan, input bit f);
        int t;
        bit s;
        bit all_diff;
        all_diff = 1'b1;
        t = chan ? hb.size() - 1 : ha.size() - 1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = t - 2 - k;
            s = 1'b0;
            if (idx >= 0) s = chan ? hb[idx] : ha[idx];
            if (s == f) all_diff = 1'b0;
        end
        return all_diff;
    endfunction

    task automatic model_step(input bit a, input bit b, input bit rst);
        logic [1:0] seq [5];
        logic [1:0] lvl;
        m_enter = 1'b0;
        m_exit  = 1'b0;
        if (rst) begin
            ha.delete();
            hb.delete();
            m_fa = 0; m_fb = 0; m_dir = 0; m_pos = 0; m_err = 0;
            return;
        end
        lvl = {m_fa, m_fb};
        if (m_err) begin
            if (lvl == 2'b00) m_err = 0;
        end else if (m_dir == 0) begin
            if (lvl == 2'b10)      begin m_dir = 1; m_pos = 1; end
            else if (lvl == 2'b01) begin m_dir = 2; m_pos = 1; end
            else if (lvl == 2'b11) m_err = 1;
        end else begin
            if (m_dir == 1) begin
                seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01; seq[4] = 2'b00;
            end else begin
                seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10; seq[4] = 2'b00;
            end
            if (lvl == seq[m_pos]) begin
                // hold position
            end else if (lvl == seq[m_pos + 1]) begin
                m_pos++;
                if (m_pos == 4) begin
                    if (m_dir == 1) m_enter = 1; else m_exit = 1;
                    m_dir = 0;
                end
            end else if (lvl == seq[m_pos - 1]) begin
                m_pos--;
                if (m_pos == 0) m_dir = 0;
            end else begin
                m_err = 1;
                m_dir = 0;
            end
        end
        ha.push_back(a);
        hb.push_back(b);
        if (window_differs(1'b0, m_fa)) m_fa = ~m_fa;
        if (window_differs(1'b1, m_fb)) m_fb = ~m_fb;
    endtask

    task automatic tick(input bit a, input bit b, input bit rst);
        beam_a_raw = a;
        beam_b_raw = b;
        reset      = rst;
        @(posedge clk);
        cyc++;
        model_step(a, b, rst);
        #1;
        check("beam_a", beam_a, m_fa);
        check("beam_b", beam_b, m_fb);
        check("enter_pulse", enter_pulse, m_enter);
        check("exit_pulse", exit_pulse, m_exit);
        check("busy", busy, (m_dir != 0) || m_err);
        check("fault", fault, m_err);
        check("pulse_exclusive", enter_pulse & exit_pulse, 0);
        if (enter_pulse) begin enter_cnt++; last_enter_cyc = cyc; end
        if (exit_pulse)  begin exit_cnt++;  last_exit_cyc  = cyc; end
        if (busy)   busy_seen  = 1;
        if (fault)  fault_seen = 1;
        if (beam_a) a_seen     = 1;
    endtask

    task automatic hold(input bit a, input bit b, input int n);
        for (int i = 0; i < n; i++) tick(a, b, 1'b0);
    endtask

    task automatic clear_obs();
        enter_cnt = 0; exit_cnt = 0;
        last_enter_cyc = -1; last_exit_cyc = -1;
        busy_seen = 0; fault_seen = 0; a_seen = 0;
    endtask

    initial begin
        int rel;
        int rise;
        reset      = 1'b1;
        beam_a_raw = 1'b0;
        beam_b_raw = 1'b0;

        // Reset state.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
        check("reset_outputs", {beam_a, beam_b, enter_pulse, exit_pulse, busy, fault}, 6'b0);
        hold(0, 0, 8);

        // Stable rise of A appears 6 edges after the raw change.
        rel = cyc; rise = -1;
        for (int i = 0; i < 20 && rise < 0; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (beam_a) rise = cyc - rel;
        end
        check("a_rise_latency", rise, N + 2);
        hold(1, 0, 4);
        hold(0, 0, 14);
        check("a_release_idle", busy, 0);

        // Short raw glitch never reaches the filtered level.
        clear_obs();
        hold(1, 0, N - 1);
        hold(0, 0, 14);
        check("glitch_a_seen", a_seen, 0);
        check("glitch_busy_seen", busy_seen, 0);

        // Full entry passage.
        clear_obs();
        hold(1, 0, 10);
        hold(1, 1, 10);
        hold(0, 1, 10);
        rel = cyc;
        hold(0, 0, 12);
        check("enter_count", enter_cnt, 1);
        check("enter_exit_count", exit_cnt, 0);
        check("enter_timing", last_enter_cyc - rel, N + 3);

        // Full exit passage.
        clear_obs();
        hold(0, 1, 10);
        hold(1, 1, 10);
        hold(1, 0, 10);
        rel = cyc;
        hold(0, 0, 12);
        check("exit_count", exit_cnt, 1);
        check("exit_enter_count", enter_cnt, 0);
        check("exit_timing", last_exit_cyc - rel, N + 3);

        // Back-to-back entries each produce one pulse.
        clear_obs();
        for (int p = 0; p < 2; p++) begin
            hold(1, 0, 8); hold(1, 1, 8); hold(0, 1, 8); hold(0, 0, 9);
        end
        check("back_to_back_enters", enter_cnt, 2);

        // Backing out of the gate.
        clear_obs();
        hold(1, 0, 10);
        hold(0, 0, 12);
        check("backout_busy_seen", busy_seen, 1);
        check("backout_busy_final", busy, 0);
        check("backout_pulses", enter_cnt + exit_cnt, 0);

        // Both beams at once from IDLE.
        clear_obs();
        hold(1, 1, 10);
        check("both_fault_high", fault, 1);
        hold(0, 0, 12);
        check("both_fault_cleared", fault, 0);
        check("both_busy_cleared", busy, 0);
        check("both_pulses", enter_cnt + exit_cnt, 0);

        // Reset mid-passage while in IN2, beams kept broken.
        clear_obs();
        hold(1, 0, 10);
        hold(1, 1, 10);
        check("in2_busy", busy, 1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1);
        check("midreset_outputs", {beam_a, beam_b, enter_pulse, exit_pulse, busy, fault}, 6'b0);
        rel = cyc; rise = -1;
        for (int i = 0; i < 20 && rise < 0; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (beam_a && beam_b) rise = cyc - rel;
        end
        check("reacquire_latency", rise, N + 2);
        hold(1, 1, 4);
        hold(0, 0, 14);
        check("midreset_pulses", enter_cnt + exit_cnt, 0);

        // Randomized beam activity with occasional reset.
        for (int s = 0; s < 250; s++) begin
            bit ra, rb;
            int dur;
            ra  = 1'($urandom_range(0, 1));
            rb  = 1'($urandom_range(0, 1));
            dur = $urandom_range(1, 12);
            if ($urandom_range(0, 39) == 0) begin
                tick(ra, rb, 1'b1);
                tick(ra, rb, 1'b1);
            end
            hold(ra, rb, dur);
        end
        hold(0, 0, 20);
        check("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gate_pass_decoder.md
GATE_PASS_DECODER -- requirements
Module: gate_pass_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required before a filtered beam level changes (legal range 2..255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port beam_a_raw  input  1  asynchronous outer-gate sensor, 1 = beam broken.
REQ-005 SHALL have port beam_b_raw  input  1  asynchronous inner-gate sensor, 1 = beam broken.
REQ-006 SHALL have port beam_a  output  1  debounced level of A.
REQ-007 SHALL have port beam_b  output  1  debounced level of B.
REQ-008 SHALL have port enter_pulse  output  1  one-cycle strobe: one complete A-to-B passage.
REQ-009 SHALL have port exit_pulse  output  1  one-cycle strobe: one complete B-to-A passage.
REQ-010 SHALL have port busy  output  1  high when the FSM is in any state other than IDLE.
REQ-011 SHALL have port fault  output  1  high while the FSM is in ERR.

Function
REQ-012 SHALL pass each raw input through a 2-flop synchronizer; the synced value lags raw by 2 edges.
REQ-013 SHALL keep an 8-bit debounce counter per channel: cleared when synced == filtered, incremented when they differ; the filtered level toggles, and the counter clears, on the edge where the counter equals DEBOUNCE_CYCLES-1 and synced still differs.
REQ-014 SHALL therefore change a filtered level exactly DEBOUNCE_CYCLES+2 edges after a stable raw change; glitches shorter than DEBOUNCE_CYCLES synced cycles SHALL NOT reach the filtered output.
REQ-015 SHALL run an FSM on {beam_a,beam_b} with states IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ERR.
REQ-016 IDLE: 10->IN1; 01->OUT1; 11->ERR; 00 stay.
REQ-017 IN1: 11->IN2; 00->IDLE (abort, no pulse); 01->ERR; 10 stay.
REQ-018 IN2: 01->IN3; 10->IN1; 00->ERR; 11 stay.
REQ-019 IN3: 00->IDLE and enter_pulse; 11->IN2; 10->ERR; 01 stay.
REQ-020 OUT1/OUT2/OUT3 SHALL mirror IN1/IN2/IN3 with the roles of A and B swapped; OUT3 with 00 SHALL give IDLE and exit_pulse.
REQ-021 ERR SHALL hold until beam levels are 00, then go to IDLE with no pulse.
REQ-022 enter_pulse/exit_pulse SHALL be registered, high for exactly one cycle, concurrent with the first IDLE cycle; they SHALL never be high together.
REQ-023 busy and fault SHALL be registered decodes of the FSM state, with no combinational path from inputs.
REQ-024 SHALL issue at most one pulse per passage, with no count saturation; back-to-back passages SHALL each produce a pulse.

Reset
REQ-025 While reset is high, synchronizer flops, filtered levels, counters and all outputs SHALL be 0, and the FSM SHALL be in IDLE.
REQ-026 Reset asserted mid-passage SHALL abandon the passage without a pulse; after release, the filtered levels SHALL re-acquire beams that are still broken per REQ-014.

Structure
REQ-027 Package gate_pkg SHALL hold the FSM state enum (3-bit encoding) and the DEBOUNCE_CYCLES default constant.
REQ-028 Sub-module debounce_filter (synchronizer plus counter, one channel) SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 beam_a_raw 0->1 held -> beam_a rises 6 edges later; a 3-cycle raw high glitch -> beam_a stays 0.
REQ-030 Raw sequence 00,10,11,01,00 with each step held 10 cycles -> one enter_pulse 7 edges after the final B release; exit_pulse stays 0.
REQ-031 Reverse sequence 00,01,11,10,00 -> one exit_pulse; enter_pulse stays 0.
REQ-032 Sequence 00,10,00 (lion backs out) -> no pulse; busy high then low.
REQ-033 Both raw inputs rise on the same cycle from IDLE -> fault=1 until both are cleared, then IDLE with no pulse.
REQ-034 Reset pulsed while in IN2 -> all outputs 0, no pulse; beams held broken -> beam_a/beam_b re-rise 6 edges after reset release.
